// File: rtl/ddr_fetch_pkg.sv
// Purpose : shared types and constants for the DDR scanline read fetcher.
// Latency : n/a (declarations only).
// Backpr. : n/a (declarations only).
package ddr_fetch_pkg;

    // Fetch sequencer states: evaluate, strobe request, force strobe low, collect data.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        WAIT  = 2'd3
    } fetch_state_t;

    // One 64-bit word spans four 16-bit address units of the [27:1] address field.
    localparam int WORD_ADDR_INC = 4;

    // All byte lanes enabled (reads always fetch whole 64-bit words).
    localparam logic [7:0] BE_ALL = 8'hFF;

endpackage

// File: rtl/ddr_fetch_fifo.sv
// Purpose : synchronous first-word-fall-through FIFO with flush and level output.
// Latency : pushed word visible on head_dat the cycle after the push edge.
// Backpr. : push ignored when full, pop ignored when empty; flush wins over both.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   flush             drop all stored words this cycle
//   push_vld/push_dat write one word
//   pop_vld           remove head word
//   head_dat          current head word, valid while !empty
//   empty, level      occupancy status
module ddr_fetch_fifo #(
    parameter int DW = 64,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    input  logic          pop_vld,
    output logic [DW-1:0] head_dat,
    output logic          empty,
    output logic [AW:0]   level
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign do_push = push_vld && !full;
    assign do_pop  = pop_vld && (level_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_dat;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign empty    = (level_q == '0);
    assign level    = level_q;

endmodule

// File: rtl/ddr_line_fetcher.sv
// Purpose : splits a scanline read into DDR bursts and buffers returned words in a FIFO.
// Latency : line_start -> mem_rd high 2 cycles later (given credit and !mem_busy).
// Backpr. : bursts issue only when the FIFO has room for the whole burst; consumer pops freely.
//
// Ports
//   DDRAM_CLK, RESET_N               clock, synchronous active-low reset
//   line_start/line_addr/line_words  new line request (addr in [27:1] units, length in words)
//   line_done                        pulse when the last word of a line lands in the FIFO
//   mem_addr/mem_burst/mem_rd        edge-triggered read request to the DDR controller
//   mem_busy/mem_dready/mem_dout     controller status and returned read data
//   fifo_rd/fifo_dout/fifo_empty/fifo_level  consumer side of the word FIFO
module ddr_line_fetcher
    import ddr_fetch_pkg::*;
#(
    parameter int BURST_MAX = 32,
    parameter int FIFO_AW   = 8,
    parameter int LEN_W     = 12
) (
    input  logic             DDRAM_CLK,
    input  logic             RESET_N,
    input  logic             line_start,
    input  logic [26:0]      line_addr,
    input  logic [LEN_W-1:0] line_words,
    output logic             line_done,
    output logic [26:0]      mem_addr,
    output logic [7:0]       mem_burst,
    output logic             mem_rd,
    input  logic             mem_busy,
    input  logic             mem_dready,
    input  logic [63:0]      mem_dout,
    input  logic             fifo_rd,
    output logic [63:0]      fifo_dout,
    output logic             fifo_empty,
    output logic [FIFO_AW:0] fifo_level
);
    localparam int FIFO_DEPTH = 1 << FIFO_AW;

    fetch_state_t     state_q, state_d;
    logic [26:0]      addr_q, addr_d;          // next burst start address
    logic [LEN_W-1:0] remaining_q, remaining_d; // words not yet requested
    logic [7:0]       inflight_q, inflight_d;  // words of the current burst still to arrive
    logic             discard_q, discard_d;    // current burst belongs to an abandoned line
    logic             mem_rd_q, mem_rd_d;
    logic [26:0]      mem_addr_q, mem_addr_d;
    logic [7:0]       mem_burst_q, mem_burst_d;
    logic             line_done_q, line_done_d;

    logic [7:0]       burst_len;
    logic [31:0]      credit;
    logic             word_rx;
    logic             last_word;
    logic             fifo_push;
    logic             fifo_flush;

    always_comb begin
        burst_len = 8'(remaining_q);
        if (32'(remaining_q) > 32'(BURST_MAX)) burst_len = 8'(BURST_MAX);
    end

    // Space the FIFO can still promise: words already stored plus words still on the way.
    assign credit = 32'(FIFO_DEPTH) - 32'(fifo_level) - 32'(inflight_q);

    // Words arriving with no burst outstanding (e.g. tail of a burst cut by reset) are dropped.
    assign word_rx   = mem_dready && (inflight_q != 8'd0) && (state_q != IDLE);
    assign last_word = word_rx && (inflight_q == 8'd1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        inflight_d  = inflight_q;
        discard_d   = discard_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_burst_d = mem_burst_q;
        line_done_d = 1'b0;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;

        case (state_q)
            IDLE: begin
                if (line_start) begin
                    addr_d      = line_addr;
                    remaining_d = line_words;
                    discard_d   = 1'b0;
                    fifo_flush  = 1'b1;
                end else if ((remaining_q != '0) && !mem_busy && (credit >= 32'(burst_len))) begin
                    state_d     = ISSUE;
                    mem_rd_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_burst_d = burst_len;
                    inflight_d  = burst_len;
                end
            end
            ISSUE:   state_d = GAP;
            // One low cycle guarantees the controller sees a fresh rising edge next time.
            GAP:     state_d = WAIT;
            WAIT:    state_d = WAIT;
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            // A new line mid-burst replaces the pending line; the burst on the bus still drains.
            if (line_start) begin
                addr_d      = line_addr;
                remaining_d = line_words;
                discard_d   = 1'b1;
            end
            if (word_rx) begin
                inflight_d = inflight_q - 8'd1;
                fifo_push  = !discard_q && !line_start;
                if (last_word) begin
                    state_d = IDLE;
                    if (discard_q || line_start) begin
                        fifo_flush = 1'b1;
                        discard_d  = 1'b0;
                    end else begin
                        remaining_d = remaining_q - LEN_W'(mem_burst_q);
                        addr_d      = addr_q + 27'(32'(mem_burst_q) * WORD_ADDR_INC);
                        line_done_d = (remaining_q == LEN_W'(mem_burst_q));
                    end
                end
            end
        end
    end

    always_ff @(posedge DDRAM_CLK) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= '0;
            discard_q   <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_burst_q <= '0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            discard_q   <= discard_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            mem_burst_q <= mem_burst_d;
            line_done_q <= line_done_d;
        end
    end

    ddr_fetch_fifo #(
        .DW (64),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (DDRAM_CLK),
        .rst_n    (RESET_N),
        .flush    (fifo_flush),
        .push_vld (fifo_push),
        .push_dat (mem_dout),
        .pop_vld  (fifo_rd),
        .head_dat (fifo_dout),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign mem_burst = mem_burst_q;
    assign line_done = line_done_q;

endmodule
